// File: rtl/wavegen_pkg.sv
// Shared types and constants for the waveform capture path.
package wavegen_pkg;
  localparam int SAMPLE_W      = 16;
  localparam int CAPTURE_DEPTH = 1024;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } cap_state_e;
endpackage

// File: rtl/capture_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no array reset.
module capture_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/sample_capture_buffer.sv
// Captures up to DEPTH samples into RAM, then drains them one word per read strobe.
module sample_capture_buffer
  import wavegen_pkg::*;
#(
  parameter int DEPTH  = CAPTURE_DEPTH,
  parameter int ADDR_W = 10,
  parameter int DATA_W = SAMPLE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       length,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              finished,
  output logic              busy,
  output logic              ready,
  output logic              underrun
);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_C = CNT_W'(DEPTH);

  cap_state_e        state_q, state_d;
  logic [ADDR_W:0]   wr_q, wr_d, rd_q, rd_d, tgt_q, tgt_d, cap_q, cap_d;
  logic              fin_q, fin_d, und_q, und_d;
  logic              zero_q, zero_d;
  logic              ram_we, ram_re;
  logic [ADDR_W:0]   len_clamp;
  logic [DATA_W-1:0] ram_rdata;

  assign len_clamp = (length > 16'(DEPTH)) ? DEPTH_C : length[ADDR_W:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      tgt_q   <= '0;
      cap_q   <= '0;
      fin_q   <= 1'b0;
      und_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      tgt_q   <= tgt_d;
      cap_q   <= cap_d;
      fin_q   <= fin_d;
      und_q   <= und_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    tgt_d   = tgt_q;
    cap_d   = cap_q;
    fin_d   = 1'b0;
    und_d   = und_q;
    zero_d  = zero_q;
    ram_we  = 1'b0;
    ram_re  = 1'b0;
    if (start) begin
      // start wins over any sample or read presented in the same cycle
      wr_d    = '0;
      rd_d    = '0;
      cap_d   = '0;
      und_d   = 1'b0;
      tgt_d   = len_clamp;
      if (length == 16'd0) begin
        state_d = IDLE;
        fin_d   = 1'b1;
      end else begin
        state_d = CAPTURE;
      end
    end else begin
      case (state_q)
        CAPTURE: if (sample_valid) begin
          ram_we = 1'b1;
          wr_d   = wr_q + 1'b1;
          if (wr_q + 1'b1 == tgt_q) begin
            state_d = DRAIN;
            fin_d   = 1'b1;
            cap_d   = tgt_q;
          end
        end
        DRAIN: if (rd_en) begin
          ram_re = 1'b1;
          zero_d = 1'b0;
          rd_d   = rd_q + 1'b1;
          if (rd_q + 1'b1 == cap_q) state_d = IDLE;
        end
        default: ;
      endcase
      // outside DRAIN there is never a word to hand out
      if (rd_en && state_q != DRAIN) begin
        und_d  = 1'b1;
        zero_d = 1'b1;
      end
    end
  end

  always_comb begin
    busy  = (state_q == CAPTURE);
    ready = (state_q == DRAIN);
  end

  assign finished = fin_q;
  assign underrun = und_q;
  assign rd_data  = zero_q ? '0 : ram_rdata;

  capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_q[ADDR_W-1:0]),
    .wdata_i (sample_in),
    .re_i    (ram_re),
    .raddr_i (rd_q[ADDR_W-1:0]),
    .rdata_o (ram_rdata)
  );
endmodule

// File: tb/tb_sample_capture_buffer.sv
// Directed scenarios with random data/valid, checked against a queue model of captured words.
module tb_sample_capture_buffer;
  logic        clk = 1'b0;
  logic        reset, start, sample_valid, rd_en;
  logic [15:0] length, sample_in;
  logic [15:0] rd_data;
  logic        finished, busy, ready, underrun;

  int          passed = 0, total = 0, fails = 0;
  logic [15:0] exp_q[$];
  logic [15:0] pat[$];
  logic        und_m;

  always #5 clk = ~clk;

  sample_capture_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .length       (length),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .finished     (finished),
    .busy         (busy),
    .ready        (ready),
    .underrun     (underrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // vmode: 0 = valid every cycle, 1 = every other cycle, 2 = random
  task automatic capture(input int len, input int vmode);
    int tgt, cyc;
    bit v;
    tgt = (len > 1024) ? 1024 : len;
    cyc = 0;
    exp_q.delete();
    und_m = 1'b0;
    start = 1'b1; length = len[15:0]; sample_valid = 1'b1; sample_in = 16'hDEAD; rd_en = 1'b0;
    tick();
    start = 1'b0;
    chk("start_finished", {31'd0, finished}, {31'd0, len == 0});
    chk("start_busy", {31'd0, busy}, {31'd0, len != 0});
    chk("start_underrun", {31'd0, underrun}, 32'd0);
    if (len == 0) begin
      chk("zero_ready", {31'd0, ready}, 32'd0);
      sample_valid = 1'b0;
      tick();
      chk("zero_fin_drop", {31'd0, finished}, 32'd0);
      chk("zero_busy", {31'd0, busy}, 32'd0);
    end else begin
      while (exp_q.size() < tgt && cyc < 5000) begin
        v = (vmode == 0) ? 1'b1 : (vmode == 1) ? bit'(cyc % 2) : bit'($urandom_range(0, 1));
        sample_valid = v;
        if (v) begin
          sample_in = (pat.size() != 0) ? pat.pop_front() : 16'($urandom);
          exp_q.push_back(sample_in);
        end else sample_in = 16'($urandom);
        tick();
        cyc++;
        if (exp_q.size() == tgt) begin
          chk("done_finished", {31'd0, finished}, 32'd1);
          chk("done_ready", {31'd0, ready}, 32'd1);
          chk("done_busy", {31'd0, busy}, 32'd0);
        end else begin
          chk("cap_finished", {31'd0, finished}, 32'd0);
          chk("cap_busy", {31'd0, busy}, 32'd1);
        end
      end
      chk("cap_count", exp_q.size(), tgt);
      // samples past the target must be dropped
      for (int i = 0; i < 3; i++) begin
        sample_valid = 1'b1;
        sample_in = (pat.size() != 0) ? pat.pop_front() : 16'($urandom);
        tick();
        chk("post_finished", {31'd0, finished}, 32'd0);
        chk("post_ready", {31'd0, ready}, 32'd1);
      end
    end
    sample_valid = 1'b0;
    pat.delete();
  endtask

  task automatic drain(input int n);
    logic [15:0] e;
    e = 16'h0;
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      tick();
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else begin
        e = 16'h0;
        und_m = 1'b1;
      end
      chk("rd_data", {16'd0, rd_data}, {16'd0, e});
      chk("rd_underrun", {31'd0, underrun}, {31'd0, und_m});
      chk("rd_ready", {31'd0, ready}, {31'd0, exp_q.size() != 0});
    end
    rd_en = 1'b0;
    tick();
    chk("rd_hold", {16'd0, rd_data}, {16'd0, e});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; length = 16'd0; sample_in = 16'd0;
    sample_valid = 1'b0; rd_en = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
    chk("rst_finished", {31'd0, finished}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);

    // basic capture of boundary values
    pat = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000};
    capture(4, 0);
    drain(4);
    chk("basic_underrun", {31'd0, underrun}, 32'd0);
    chk("basic_idle", {31'd0, ready}, 32'd0);

    // gapped valid with length clamped to depth
    for (int i = 0; i < 2000; i++) pat.push_back(16'(i));
    capture(2000, 1);
    drain(1024);
    drain(1);

    // zero length
    capture(0, 0);
    exp_q.delete();
    und_m = 1'b0;
    drain(1);

    // over-read
    capture(3, 2);
    drain(5);
    tick();
    chk("over_sticky", {31'd0, underrun}, 32'd1);

    // restart mid-drain
    capture(4, 2);
    drain(2);
    pat = '{16'hA5A5, 16'h5A5A};
    capture(2, 0);
    drain(2);
    chk("restart_underrun", {31'd0, underrun}, 32'd0);

    // random lengths
    for (int k = 0; k < 3; k++) begin
      capture($urandom_range(1, 40), 2);
      drain(exp_q.size() + 1);
    end

    // reset mid-capture
    start = 1'b1; length = 16'd8; tick(); start = 1'b0;
    sample_valid = 1'b1; sample_in = 16'h1111; tick();
    sample_in = 16'h2222; tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rstm_busy", {31'd0, busy}, 32'd0);
    chk("rstm_ready", {31'd0, ready}, 32'd0);
    chk("rstm_finished", {31'd0, finished}, 32'd0);
    chk("rstm_rd_data", {16'd0, rd_data}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      sample_in = 16'($urandom);
      tick();
      chk("rstm_no_fin", {31'd0, finished}, 32'd0);
      chk("rstm_no_busy", {31'd0, busy}, 32'd0);
    end
    sample_valid = 1'b0;
    exp_q.delete();
    und_m = 1'b0;
    drain(1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
